updi_target_responder: RTL and testbench
========================================

// Module: updi_target_responder
// PURPOSE
// Byte-level UPDI target (responder) model: the far end of updi_programmer's link.
// Pops host bytes from an RX FIFO, decodes SYNCH + LDS/STS/LDCS/STCS frames,
// serves a local byte memory and a 16-entry CS register file, and pushes replies
// (data / ACK 0x40) into a TX FIFO. Sits behind a target-side UART PHY for bench
// loopback against the programmer. The PHY strips the wire echo before this block.
// PARAMETERS
// MEM_SIZE   512   bytes of target memory; power of 2
// ADDR_BITS  9     $clog2(MEM_SIZE); address = low ADDR_BITS of received address
// UPDI_REV   3     value returned in CS[0] (STATUSA) bits 7:4
// PORTS
// clk                   in   1  system clock
// rst                   in   1  synchronous, active-high reset
// rx_fifo_data          in   8  head byte of host->target FIFO (first-word-fall-through)
// rx_fifo_empty         in   1  RX FIFO empty
// rx_fifo_rd_en         out  1  pop RX head this cycle
// tx_fifo_data          out  8  reply byte
// tx_fifo_wr_en         out  1  push tx_fifo_data this cycle
// tx_fifo_full          in   1  TX FIFO full
// break_detected        in   1  1-cycle pulse: PHY saw BREAK on the line
// frame_error           out  1  sticky: unsupported opcode seen; cleared by break/rst
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; memory not cleared; CS[1..15]=0.
// - rx_fifo_rd_en asserts only when !rx_fifo_empty and the FSM consumes a byte;
//   byte taken = rx_fifo_data same cycle. At most one pop per cycle.
// - tx_fifo_wr_en asserts only when !tx_fifo_full; while full, FSM holds in SEND/ACK.
// - States: IDLE -> OPCODE -> ADDR_LO -> [ADDR_HI] -> (LDS: SEND | STS: ACK_A ->
//   DATA -> ACK_D) -> IDLE; CS_DATA (STCS) -> IDLE; LDCS -> SEND -> IDLE; ERROR.
// - IDLE: pop bytes; 0x55 -> OPCODE; any other byte discarded silently.
// - OPCODE decode (one byte): [7:5]=000 LDS, 010 STS, 100 LDCS, 110 STCS;
//   LDS/STS: [3:2] addr size (00=1 byte, 01=2 bytes), [1:0] data size must be 00.
//   Any other encoding (incl. 24-bit addr, word data, LD/ST/REPEAT/KEY) -> ERROR,
//   frame_error=1. LDCS/STCS: [3:0]=CS index.
// - Address: little-endian, low byte first; 1-byte form zero-extends; upper bits
//   above ADDR_BITS ignored (wraps modulo MEM_SIZE).
// - LDS: after last address byte, next cycle enters SEND, pushes mem[addr].
// - STS: push ACK 0x40 after address; pop data byte; write mem[addr] on the pop
//   cycle; push ACK 0x40; return to IDLE.
// - LDCS: push CS[idx]; CS[0] reads {UPDI_REV[3:0],4'h0} (read-only).
// - STCS: pop one data byte into CS[idx]; idx 0 write ignored; no reply byte.
// - Reply latency: first TX push no earlier than 1 cycle after final RX pop of the
//   request; exactly 1 cycle when TX not full.
// - ERROR: pop and discard every byte; exit only via break_detected or rst.
// - break_detected (any state, wins over a same-cycle pop): FSM=IDLE, frame_error=0,
//   pending reply dropped, CS/memory kept; no pop that cycle.
// - rst mid-frame: frame abandoned, no further TX bytes; next frame needs SYNCH.
// TESTING
// 1 RX 55 80 -> TX exactly one byte 0x30; frame_error=0.
// 2 RX 55 40 10 (ACK 40) A5 (ACK 40), then 55 00 10 -> TX 40,40,A5.
// 3 RX 55 44 34 12 5A then 55 04 34 12 -> mem[0x034]=5A (wrap, MEM_SIZE=512); TX 40,40,5A.
// 4 RX 55 C3 7E, 55 83 -> TX 7E only; 55 C0 FF, 55 80 -> TX 30 (CS0 read-only).
// 5 RX 55 01 -> no TX, frame_error=1; then 55 80 ignored; break pulse,
//   55 80 -> TX 30, frame_error=0.
// 6 Hold tx_fifo_full=1 during LDS reply 20 cycles -> wr_en stays 0, one push after release;
//   assert rst after STS addr byte -> no ACK; next 55 80 -> TX 30.

Source files
------------

// File: rtl/updi_target_responder.sv
// Byte-level UPDI target: decodes SYNCH + LDS/STS/LDCS/STCS frames from an RX FIFO,
// serves a local byte memory and CS register file, and pushes replies into a TX FIFO.
module updi_target_responder #(
  parameter int MEM_SIZE  = 512,
  parameter int ADDR_BITS = $clog2(MEM_SIZE),
  parameter int UPDI_REV  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_fifo_data,
  input  logic       rx_fifo_empty,
  output logic       rx_fifo_rd_en,
  output logic [7:0] tx_fifo_data,
  output logic       tx_fifo_wr_en,
  input  logic       tx_fifo_full,
  input  logic       break_detected,
  output logic       frame_error
);

  localparam logic [7:0] SYNCH   = 8'h55;
  localparam logic [7:0] ACK     = 8'h40;
  localparam logic [7:0] STATUSA = {4'(UPDI_REV), 4'h0};

  typedef enum logic [3:0] {
    S_IDLE, S_OPCODE, S_ADDR_LO, S_ADDR_HI, S_SEND,
    S_ACK_A, S_DATA, S_ACK_D, S_CS_DATA, S_ERROR
  } state_t;

  state_t                state, next;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  two_byte, is_sts, is_cs;
  logic [3:0]            idx;
  logic [7:0]            cs [1:15];
  logic [7:0]            mem [MEM_SIZE];
  logic                  pop, push, can_pop, can_push, op_bad;
  logic [7:0]            tx_byte, cs_rd;

  // break and reset both suppress any FIFO traffic in their cycle
  assign can_pop  = !rx_fifo_empty && !rst && !break_detected;
  assign can_push = !tx_fifo_full && !rst && !break_detected;

  // Legal: LDS/STS with 1- or 2-byte address and byte data; LDCS/STCS any index.
  assign op_bad = rx_fifo_data[5] ||
                  (!rx_fifo_data[7] && (rx_fifo_data[3] || (rx_fifo_data[1:0] != 2'b00)));

  assign cs_rd = (idx == 4'd0) ? STATUSA : cs[idx];

  always_comb begin
    next    = state;
    pop     = 1'b0;
    push    = 1'b0;
    tx_byte = 8'h00;
    case (state)
      S_IDLE: if (can_pop) begin
        pop = 1'b1;
        if (rx_fifo_data == SYNCH) next = S_OPCODE;
      end
      S_OPCODE: if (can_pop) begin
        pop = 1'b1;
        if (op_bad)               next = S_ERROR;
        else if (rx_fifo_data[7]) next = rx_fifo_data[6] ? S_CS_DATA : S_SEND;
        else                      next = S_ADDR_LO;
      end
      S_ADDR_LO: if (can_pop) begin
        pop = 1'b1;
        if (two_byte)    next = S_ADDR_HI;
        else if (is_sts) next = S_ACK_A;
        else             next = S_SEND;
      end
      S_ADDR_HI: if (can_pop) begin
        pop  = 1'b1;
        next = is_sts ? S_ACK_A : S_SEND;
      end
      S_SEND: begin
        tx_byte = is_cs ? cs_rd : mem[addr_q];
        if (can_push) begin
          push = 1'b1;
          next = S_IDLE;
        end
      end
      S_ACK_A: begin
        tx_byte = ACK;
        if (can_push) begin
          push = 1'b1;
          next = S_DATA;
        end
      end
      S_DATA: if (can_pop) begin
        pop  = 1'b1;
        next = S_ACK_D;
      end
      S_ACK_D: begin
        tx_byte = ACK;
        if (can_push) begin
          push = 1'b1;
          next = S_IDLE;
        end
      end
      S_CS_DATA: if (can_pop) begin
        pop  = 1'b1;
        next = S_IDLE;
      end
      S_ERROR: pop = can_pop;
      default: next = S_IDLE;
    endcase
  end

  assign rx_fifo_rd_en = pop;
  assign tx_fifo_wr_en = push;
  assign tx_fifo_data  = push ? tx_byte : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_error <= 1'b0;
      addr_q      <= '0;
      two_byte    <= 1'b0;
      is_sts      <= 1'b0;
      is_cs       <= 1'b0;
      idx         <= '0;
      for (int i = 1; i < 16; i++) cs[i] <= '0;
    end else if (break_detected) begin
      state       <= S_IDLE;
      frame_error <= 1'b0;
    end else begin
      state <= next;
      if (state == S_OPCODE && pop) begin
        two_byte <= rx_fifo_data[2];
        is_sts   <= rx_fifo_data[6];
        is_cs    <= rx_fifo_data[7];
        idx      <= rx_fifo_data[3:0];
        if (op_bad) frame_error <= 1'b1;
      end
      // high address bits beyond ADDR_BITS fall away, giving modulo-MEM_SIZE wrap
      if (state == S_ADDR_LO && pop) addr_q <= ADDR_BITS'(rx_fifo_data);
      if (state == S_ADDR_HI && pop) addr_q <= ADDR_BITS'({rx_fifo_data, 8'h00} | 16'(addr_q));
      if (state == S_CS_DATA && pop && idx != 4'd0) cs[idx] <= rx_fifo_data;
    end
  end

  // memory contents survive reset
  always_ff @(posedge clk) begin
    if (state == S_DATA && pop) mem[addr_q] <= rx_fifo_data;
  end

endmodule

// File: tb/tb_updi_target_responder.sv
// Randomized + directed scoreboard bench for updi_target_responder.
module tb_updi_target_responder;
  localparam int MEM_SIZE = 512;
  localparam int UPDI_REV = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_empty;
  logic       rx_fifo_rd_en;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_wr_en;
  logic       tx_fifo_full;
  logic       break_detected;
  logic       frame_error;

  updi_target_responder #(.MEM_SIZE(MEM_SIZE), .ADDR_BITS(9), .UPDI_REV(UPDI_REV)) dut (
    .clk(clk), .rst(rst), .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_rd_en(rx_fifo_rd_en), .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_full(tx_fifo_full), .break_detected(break_detected), .frame_error(frame_error));

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, push_cnt = 0, last_pop = 0, last_push = 0;
  bit pop_pend = 1'b0, rnd_full = 1'b0;
  logic [7:0] mm [int];
  int keys[$];
  logic [7:0] mcs [16];

  task automatic refresh();
    rx_fifo_empty = (rxq.size() == 0);
    rx_fifo_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    refresh();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired", name);
  endtask

  // Monitor: sample between clock edges, score TX pushes against the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (tx_fifo_wr_en) begin
      push_cnt++;
      last_push = cyc;
      vectors++;
      if (tx_fifo_full) begin
        miscompares++;
        $display("FAIL tx_push_while_full: got wr_en=1 expected 0");
      end else if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: got %0h expected no byte", tx_fifo_data);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (tx_fifo_data !== e) begin
          miscompares++;
          $display("FAIL tx_byte: got %0h expected %0h", tx_fifo_data, e);
        end
      end
    end
    if (rx_fifo_rd_en) begin
      last_pop = cyc;
      if (rxq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_pop_empty: got rd_en=1 expected 0");
      end
    end
    pop_pend = rx_fifo_rd_en;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend && rxq.size() != 0) begin
      void'(rxq.pop_front());
      refresh();
    end
  end

  always @(posedge clk) begin
    if (rnd_full) begin
      #1;
      tx_fifo_full = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((rxq.size() != 0 || expq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      timeout(name);
      expq.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_rx(input string name);
    int n = 0;
    while (rxq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) timeout(name);
    #2;
  endtask

  // Reference model: each frame's reply is computed from the protocol rules directly.
  task automatic lds(input int a, input bit two);
    int k;
    k = a % MEM_SIZE;
    send(8'h55); send(two ? 8'h04 : 8'h00); send(8'(a));
    if (two) send(8'(a >> 8));
    expq.push_back(mm.exists(k) ? mm[k] : 8'hxx);
  endtask

  task automatic sts(input int a, input bit two, input logic [7:0] d);
    int k;
    k = a % MEM_SIZE;
    send(8'h55); send(two ? 8'h44 : 8'h40); send(8'(a));
    if (two) send(8'(a >> 8));
    expq.push_back(8'h40);
    send(d);
    expq.push_back(8'h40);
    if (!mm.exists(k)) keys.push_back(k);
    mm[k] = d;
  endtask

  task automatic ldcs(input int i);
    send(8'h55); send(8'(8'h80 + i));
    expq.push_back(i == 0 ? 8'(UPDI_REV * 16) : mcs[i]);
  endtask

  task automatic stcs(input int i, input logic [7:0] d);
    send(8'h55); send(8'(8'hC0 + i)); send(d);
    if (i != 0) mcs[i] = d;
  endtask

  initial begin
    int saved;
    for (int i = 0; i < 16; i++) mcs[i] = 8'h00;
    rst = 1'b1; tx_fifo_full = 1'b0; break_detected = 1'b0;
    refresh();
    send(8'h12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", rx_fifo_rd_en, 0);
    check("rst_wr_en", tx_fifo_wr_en, 0);
    check("rst_tx_data", tx_fifo_data, 0);
    check("rst_frame_error", frame_error, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    drain("rst_junk");

    // LDCS STATUSA, then reply latency after the final request pop
    ldcs(0); drain("t1");
    check("t1_frame_error", frame_error, 0);
    check("t1_latency", last_push - last_pop, 1);

    sts(16'h10, 0, 8'hA5); lds(16'h10, 0); drain("t2");
    sts(16'h1234, 1, 8'h5A); lds(16'h1234, 1); lds(16'h0034, 0); drain("t3");
    stcs(3, 8'h7E); ldcs(3); stcs(0, 8'hFF); ldcs(0); drain("t4");

    // unsupported opcode -> sticky error, bytes swallowed until break
    send(8'h55); send(8'h01); drain("t5a");
    check("t5_err_set", frame_error, 1);
    saved = push_cnt;
    send(8'h55); send(8'h80); drain("t5b");
    check("t5_err_swallow", push_cnt, saved);
    check("t5_err_sticky", frame_error, 1);
    break_detected = 1'b1;
    ldcs(0);
    @(posedge clk); #2;
    break_detected = 1'b0;
    check("t5_err_clr", frame_error, 0);
    drain("t5c");

    // reply held off while TX full
    tx_fifo_full = 1'b1;
    lds(16'h10, 0);
    wait_rx("t6_rx");
    saved = push_cnt;
    repeat (20) @(posedge clk);
    #2;
    check("t6_hold", push_cnt, saved);
    tx_fifo_full = 1'b0;
    drain("t6_release");
    check("t6_one_push", push_cnt, saved + 1);

    // reset after STS address bytes abandons the frame
    tx_fifo_full = 1'b1;
    send(8'h55); send(8'h40); send(8'h10);
    wait_rx("t6_sts_rx");
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0; tx_fifo_full = 1'b0;
    saved = push_cnt;
    repeat (5) @(posedge clk);
    #2;
    check("t6_rst_no_ack", push_cnt, saved);
    for (int i = 1; i < 16; i++) mcs[i] = 8'h00;
    ldcs(0); ldcs(3); lds(16'h10, 0); drain("t6_after_rst");

    // randomized traffic with random TX back-pressure
    rnd_full = 1'b1;
    for (int f = 0; f < 400; f++) begin
      int kind;
      if ($urandom_range(0, 4) == 0) begin
        logic [7:0] j;
        j = 8'($urandom_range(0, 255));
        if (j == 8'h55) j = 8'h56;
        send(j);
      end
      kind = (keys.size() == 0) ? 1 : int'($urandom_range(0, 4));
      case (kind)
        0: begin
          int k, a;
          bit two;
          k = keys[$urandom_range(0, keys.size() - 1)];
          two = (k >= 256) || $urandom_range(0, 1) == 1;
          a = two ? k + MEM_SIZE * int'($urandom_range(0, 127)) : k;
          lds(a, two);
        end
        1: begin
          bit two;
          two = $urandom_range(0, 1) == 1;
          sts(two ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 255)), two,
              8'($urandom_range(0, 255)));
        end
        2: ldcs(int'($urandom_range(0, 15)));
        3: stcs(int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        default: lds(keys[$urandom_range(0, keys.size() - 1)] + MEM_SIZE, 1);
      endcase
      if ($urandom_range(0, 3) == 0) drain("rnd");
    end
    drain("rnd_end");
    rnd_full = 1'b0;
    @(posedge clk); #2;
    tx_fifo_full = 1'b0;
    check("end_frame_error", frame_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
